// File: rtl/adc_stim_gen.sv
// adc_stim_gen: multi-channel ADC sample generator (wrap/saturate/triangle/LFSR) with round-robin valid/ready output.
// Define ADC_STIM_CHAN_OFFSET_EN to offset each channel's reset/restart value by its channel index.
module adc_stim_gen #(
  parameter int          DWIDTH    = 32,
  parameter int          NCHAN     = 4,
  parameter int          CHW       = 4,
  parameter int          RESET_VAL = 1,
  parameter logic [31:0] POLY      = 32'h80200003
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic [1:0]        mode,
  input  logic [15:0]       period,
  input  logic [DWIDTH-1:0] step,
  input  logic [DWIDTH-1:0] start_val,
  output logic [DWIDTH-1:0] sample_data,
  output logic [CHW-1:0]    sample_chan,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [15:0]       drop_count
);
  localparam int IW = NCHAN > 1 ? $clog2(NCHAN) : 1;
  localparam logic [DWIDTH-1:0] POLY_W = DWIDTH'(POLY);
`ifdef ADC_STIM_CHAN_OFFSET_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  logic [15:0]       cnt_q, cnt_d, p_m1, drop_q, drop_d;
  logic [CHW-1:0]    ptr_q, ptr_d, chan_q, chan_d;
  logic [DWIDTH-1:0] acc_q [NCHAN];
  logic [NCHAN-1:0]  dir_q;
  logic [DWIDTH-1:0] acc_cur, acc_nxt, data_q, data_d;
  logic [DWIDTH:0]   sum;
  logic              dir_cur, dir_nxt, tick, free, take, drop, valid_q, valid_d;
  assign p_m1    = period == 16'd0 ? 16'd0 : period - 16'd1;
  assign tick    = enable && cnt_q >= p_m1;
  assign free    = !valid_q || sample_ready;
  assign take    = tick && !restart && free;
  assign drop    = tick && !restart && !free;
  assign acc_cur = acc_q[ptr_q[IW-1:0]];
  assign dir_cur = dir_q[ptr_q[IW-1:0]];
  assign sum     = {1'b0, acc_cur} + {1'b0, step};
  always_comb begin
    acc_nxt = sum[DWIDTH-1:0];
    dir_nxt = dir_cur;
    case (mode)
      2'b01: acc_nxt = sum[DWIDTH] ? '1 : sum[DWIDTH-1:0];
      2'b10: begin
        if (!dir_cur && sum[DWIDTH]) begin
          dir_nxt = 1'b1;
          acc_nxt = acc_cur - step;
        end else if (dir_cur) begin
          dir_nxt = acc_cur >= step;
          acc_nxt = acc_cur < step ? sum[DWIDTH-1:0] : acc_cur - step;
        end
      end
      2'b11: acc_nxt = acc_cur == '0 ? DWIDTH'(1) : (acc_cur >> 1) ^ (acc_cur[0] ? POLY_W : '0);
      default: ;
    endcase
  end
  always_comb begin
    cnt_d   = restart ? 16'd0 : !enable ? cnt_q : tick ? 16'd0 : cnt_q + 16'd1;
    ptr_d   = restart ? '0 : !take ? ptr_q : ptr_q == CHW'(NCHAN - 1) ? '0 : ptr_q + CHW'(1);
    valid_d = take || (valid_q && !sample_ready);
    data_d  = take ? acc_cur : data_q;
    chan_d  = take ? ptr_q : chan_q;
    drop_d  = drop && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      ptr_q   <= '0;
      dir_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      drop_q  <= '0;
      for (int k = 0; k < NCHAN; k++) acc_q[k] <= DWIDTH'(RESET_VAL + OFF * k);
    end else begin
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      drop_q  <= drop_d;
      if (restart) begin
        dir_q <= '0;
        for (int k = 0; k < NCHAN; k++) acc_q[k] <= start_val + DWIDTH'(OFF * k);
      end else if (take) begin
        acc_q[ptr_q[IW-1:0]] <= acc_nxt;
        dir_q[ptr_q[IW-1:0]] <= dir_nxt;
      end
    end
  end
  assign sample_data  = data_q;
  assign sample_chan  = chan_q;
  assign sample_valid = valid_q;
  assign drop_count   = drop_q;
endmodule

// File: tb/tb_adc_stim_gen.sv
// tb_adc_stim_gen: randomized and directed bench for adc_stim_gen against a cycle-level behavioural model.
module tb_adc_stim_gen;
  localparam int NC = 3;
`ifdef ADC_STIM_CHAN_OFFSET_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  logic        clk, rst, enable, restart, svalid, sready;
  logic [1:0]  mode, schan;
  logic [15:0] period, dcount;
  logic [31:0] step, start_val, sdata;
  int checks = 0, errors = 0;
  adc_stim_gen #(.DWIDTH(32), .NCHAN(NC), .CHW(2)) dut (
    .clock(clk), .reset(rst), .enable(enable), .restart(restart), .mode(mode),
    .period(period), .step(step), .start_val(start_val), .sample_data(sdata),
    .sample_chan(schan), .sample_valid(svalid), .sample_ready(sready), .drop_count(dcount));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] lfsr(input logic [31:0] a);
    return a == 0 ? 32'd1 : (a >> 1) ^ (a[0] ? 32'h80200003 : 32'd0);
  endfunction
  function automatic logic [32:0] next_acc(input logic [1:0] md, input logic [31:0] a, input logic dn, input logic [31:0] s);
    longint unsigned sum = longint'(a) + longint'(s);
    longint unsigned mx = 64'hFFFF_FFFF;
    case (md)
      2'd0: return {dn, 32'(sum)};
      2'd1: return {dn, sum > mx ? 32'hFFFF_FFFF : 32'(sum)};
      2'd2: if (!dn) return sum > mx ? {1'b1, a - s} : {1'b0, 32'(sum)};
            else return a < s ? {1'b0, 32'(sum)} : {1'b1, a - s};
      default: return {dn, lfsr(a)};
    endcase
  endfunction
  logic [31:0] m_acc [NC];
  logic        m_dir [NC];
  logic [31:0] m_data;
  logic [1:0]  m_chan;
  logic        m_valid;
  int          m_cnt, m_ptr, m_drop;
  always @(posedge clk) begin
    int p;
    logic tick, free;
    logic [32:0] r;
    if (rst) begin
      m_cnt = 0; m_ptr = 0; m_valid = 0; m_data = 0; m_chan = 0; m_drop = 0;
      for (int k = 0; k < NC; k++) begin m_acc[k] = 32'(1 + OFF * k); m_dir[k] = 0; end
    end else begin
      p = period == 0 ? 1 : int'(period);
      tick = enable && m_cnt >= p - 1;
      free = !m_valid || sready;
      if (tick && !restart && free) begin
        m_data = m_acc[m_ptr]; m_chan = 2'(m_ptr); m_valid = 1;
        r = next_acc(mode, m_acc[m_ptr], m_dir[m_ptr], step);
        m_acc[m_ptr] = r[31:0]; m_dir[m_ptr] = r[32];
        m_ptr = (m_ptr + 1) % NC;
      end else if (m_valid && sready) m_valid = 0;
      if (tick && !restart && !free && m_drop < 65535) m_drop++;
      if (restart) begin
        m_cnt = 0; m_ptr = 0;
        for (int k = 0; k < NC; k++) begin m_acc[k] = start_val + 32'(OFF * k); m_dir[k] = 0; end
      end else if (enable) m_cnt = tick ? 0 : m_cnt + 1;
    end
  end
  always @(negedge clk) begin
    chk("valid", svalid, m_valid);
    chk("data", sdata, m_data);
    chk("chan", schan, m_chan);
    chk("drop_count", dcount, 16'(m_drop));
  end
  logic [1:0]  lc[$];
  logic [31:0] ld[$];
  always @(posedge clk)
    if (!rst && svalid && sready) begin lc.push_back(schan); ld.push_back(sdata); end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic restart_seq(input logic [31:0] sv);
    enable = 0; sready = 1;
    cyc(4);
    lc.delete(); ld.delete();
    start_val = sv; restart = 1;
    cyc(1);
    restart = 0; enable = 1;
  endtask
  task automatic ch0(output logic [31:0] v[$]);
    v.delete();
    foreach (lc[i]) if (lc[i] == 0) v.push_back(ld[i]);
  endtask
  initial begin
    logic [31:0] v[$];
    logic [31:0] hd;
    logic [1:0]  hc;
    logic        got;
    int          d0, zeros;
    rst = 1; enable = 0; restart = 0; mode = 0; period = 2; step = 1; start_val = 0; sready = 1;
    cyc(2);
    rst = 0;
    chk("rst_valid", svalid, 0); chk("rst_data", sdata, 0);
    chk("rst_chan", schan, 0); chk("rst_drop", dcount, 0);
    enable = 1;
    cyc(14);
    chk("wrap_count", lc.size(), 6);
    if (lc.size() >= 4) begin
      chk("wrap0_c", lc[0], 0); chk("wrap0_d", ld[0], 1);
      chk("wrap1_c", lc[1], 1); chk("wrap1_d", ld[1], 32'(1 + OFF));
      chk("wrap2_c", lc[2], 2); chk("wrap2_d", ld[2], 32'(1 + 2 * OFF));
      chk("wrap3_c", lc[3], 0); chk("wrap3_d", ld[3], 2);
    end
    restart_seq(32'hFFFF_FFFE);
    cyc(30);
    ch0(v);
    chk("rwrap_n", v.size() >= 4, 1);
    if (v.size() >= 4) begin
      chk("rwrap0", v[0], 32'hFFFF_FFFE); chk("rwrap1", v[1], 32'hFFFF_FFFF);
      chk("rwrap2", v[2], 0); chk("rwrap3", v[3], 1);
    end
    mode = 1; period = 1; step = 4;
    restart_seq(32'hFFFF_FFFA);
    cyc(16);
    ch0(v);
    if (v.size() >= 4) begin
      chk("sat0", v[0], 32'hFFFF_FFFA); chk("sat1", v[1], 32'hFFFF_FFFE);
      chk("sat2", v[2], 32'hFFFF_FFFF); chk("sat3", v[3], 32'hFFFF_FFFF);
    end else chk("sat_n", v.size(), 4);
    mode = 2;
    restart_seq(32'hFFFF_FFFA);
    cyc(16);
    ch0(v);
    if (v.size() >= 4) begin
      chk("tri0", v[0], 32'hFFFF_FFFA); chk("tri1", v[1], 32'hFFFF_FFFE);
      chk("tri2", v[2], 32'hFFFF_FFFA); chk("tri3", v[3], 32'hFFFF_FFF6);
    end else chk("tri_n", v.size(), 4);
    mode = 0; period = 2; step = 1;
    restart_seq(0);
    sready = 0;
    d0 = dcount;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = svalid; end
    chk("bp_valid_seen", got, 1);
    hd = sdata; hc = schan;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_d", sdata, hd); chk("bp_hold_c", schan, hc);
    end
    sready = 1;
    cyc(8);
    chk("bp_drops", dcount - 16'(d0), 5);
    chk("bp_held_c", lc.size() > 1 ? lc[0] : 2'd3, 0);
    chk("bp_held_d", hd, 0);
    if (lc.size() > 3) begin
      chk("bp_next_c", lc[1], 1); chk("bp_next_d", ld[1], 32'(OFF));
      chk("bp_ch0_c", lc[3], 0); chk("bp_ch0_d", ld[3], 1);
    end else chk("bp_n", lc.size(), 4);
    mode = 3; period = 1;
    restart_seq(0);
    cyc(320);
    ch0(v);
    if (v.size() >= 102) begin
      chk("lfsr0", v[0], 0); chk("lfsr1", v[1], 1); chk("lfsr2", v[2], 32'h8020_0003);
      zeros = 0;
      for (int i = 1; i <= 100; i++) begin
        chk("lfsr_seq", v[i + 1], lfsr(v[i]));
        if (v[i] == 0) zeros++;
      end
      chk("lfsr_nonzero", zeros, 0);
    end else chk("lfsr_n", v.size(), 102);
    mode = 0; period = 0;
    cyc(3);
    lc.delete(); ld.delete();
    cyc(10);
    chk("p0_count", lc.size(), 10);
    enable = 0; sready = 0;
    d0 = dcount;
    cyc(5);
    chk("en0_valid", svalid, 1); chk("en0_drops", dcount - 16'(d0), 0);
    lc.delete(); ld.delete();
    sready = 1;
    cyc(5);
    chk("en0_accept", lc.size(), 1); chk("en0_clear", svalid, 0);
    rst = 1; cyc(1); rst = 0;
    period = 1; step = 1; mode = 0; sready = 0; enable = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = dcount == 3; end
    chk("mr_drop3", got, 1); chk("mr_valid1", svalid, 1);
    rst = 1; cyc(1); rst = 0;
    chk("mr_valid", svalid, 0); chk("mr_drop", dcount, 0);
    lc.delete(); ld.delete();
    sready = 1;
    cyc(4);
    if (lc.size() > 0) begin chk("mr_first_c", lc[0], 0); chk("mr_first_d", ld[0], 1); end
    else chk("mr_n", lc.size(), 1);
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 299) == 0;
      sready = $urandom_range(0, 3) != 0;
      enable = $urandom_range(0, 7) != 0;
      restart = $urandom_range(0, 49) == 0;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 19) == 0) period = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0)
        case ($urandom_range(0, 3))
          0: step = 0;
          1: step = 1;
          2: step = $urandom_range(1, 16);
          default: step = $urandom;
        endcase
      if ($urandom_range(0, 9) == 0) start_val = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 : $urandom;
      cyc(1);
    end
    rst = 0; restart = 0;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_stim_gen.md
Name: adc_stim_gen

Overview:
- Synthesizable, parametrised multi-channel ADC sample generator.
- Replaces the single free-running ramp stimulus on the CPU `adcdata` path. Usable both in benches and on-chip as a self-test source.
- Produces per-channel sequences in one of four modes: wrapping ramp, saturating ramp, triangle, pseudo-random.
- Emits samples round-robin at a programmable interval over a valid/ready handshake, and counts samples dropped under backpressure.

Parameters:
- DWIDTH, 32, sample data width in bits (minimum 4).
- NCHAN, 4, number of channels (1..16).
- CHW, 4, width of `sample_chan`; must satisfy 2^CHW >= NCHAN.
- RESET_VAL, 1, value loaded into every channel accumulator on reset.
- POLY, 32'h80200003, Galois LFSR feedback mask. Truncated to DWIDTH bits.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = interval counter runs; 0 = counter holds and no ticks occur.
- restart  in  1  one-cycle pulse: reload all accumulators with `start_val`, clear the counter, channel pointer and triangle directions.
- mode  in  2  00 wrap ramp, 01 saturating ramp, 10 triangle, 11 LFSR.
- period  in  16  sample interval in clocks; 0 is treated as 1.
- step  in  DWIDTH  increment applied per update.
- start_val  in  DWIDTH  accumulator value used by `restart`.
- sample_data  out  DWIDTH  sample value.
- sample_chan  out  CHW  channel index of `sample_data`.
- sample_valid  out  1  sample pending.
- sample_ready  in  1  consumer accepts the sample.
- drop_count  out  16  saturating count of dropped ticks.

Behaviour:
- Reset values:
  - Outputs: `sample_valid`=0, `sample_data`=0, `sample_chan`=0, `drop_count`=0.
  - Internal state: counter=0, channel pointer=0, all accumulators=RESET_VAL, all triangle directions=up.
- Reset mid-operation discards any pending sample; it is not delivered.
- Interval counter:
  - Counts 0..P-1 while `enable`=1, where P=max(period,1).
  - A tick occurs in the cycle where count==P-1; the count then returns to 0.
  - With P=1, a tick occurs every enabled cycle.
- Transfer occurs when `sample_valid` && `sample_ready`.
- On a tick, if the output slot is free (`sample_valid`=0, or a transfer in the same cycle):
  - Register `sample_data`=acc[ptr], `sample_chan`=ptr, `sample_valid`=1.
  - Update acc[ptr] per mode.
  - Advance ptr: NCHAN-1 wraps to 0.
  - Latency: tick cycle t produces `sample_valid` visible at t+1.
- On a tick with the slot occupied and no transfer:
  - The tick is dropped; acc and ptr are unchanged.
  - `drop_count` increments, saturating at 16'hFFFF.
- A transfer with no tick clears `sample_valid`. `sample_data` and `sample_chan` hold their last values.
- While `sample_valid`=1, `sample_data` and `sample_chan` are stable until transfer.
- Mode updates (w = DWIDTH, all arithmetic unsigned):
  - 00 wrap ramp: acc = (acc+step) mod 2^w.
  - 01 saturating ramp: acc = acc+step if no carry, else all-ones.
  - 10 triangle, dir up: if acc+step carries, set dir=down and acc=acc-step; else acc=acc+step.
  - 10 triangle, dir down: if acc<step, set dir=up and acc=acc+step; else acc=acc-step.
  - 11 LFSR: acc = (acc>>1) ^ (acc[0] ? POLY : 0). If acc==0 before the update, load 1 instead.
- A `mode` change applies from the next accumulator update; no reload occurs.
- `step`=0: ramps and triangle hold their value; LFSR is unaffected.
- `restart`:
  - Overrides any simultaneous tick: no sample is produced and no drop is counted.
  - Does not touch a pending output sample or `drop_count`.
- `enable`=0 does not block the handshake; a pending sample can still be accepted.
- `period` changes take effect immediately. If count >= new P-1, the next enabled cycle ticks and clears the count.

Optional Feature:
- Macro: ADC_STIM_CHAN_OFFSET_EN.
- Defined:
  - Reset loads acc[k]=RESET_VAL+k.
  - `restart` loads acc[k]=`start_val`+k, mod 2^DWIDTH.
  - Gives each channel a distinct sequence.
- Undefined: all channels load the identical value.

Test Plan:
- Wrap ramp. Setup: DWIDTH=8, NCHAN=2, period=2, step=1, mode=00, ready=1. Expect (chan,data) = (0,1),(1,1),(0,2),(1,2), one sample every 2 clocks. After `restart` with start_val=254, expect ch0 sequence 254,255,0,1.
- Saturate and triangle. Setup: NCHAN=1, period=1, start_val=250, step=4.
  - mode=01: data sequence 250,254,255,255.
  - mode=10: data sequence 250,254,250,246.
- Backpressure. Setup: period=2, ready=0 for 10 clocks from the first valid. Expect:
  - `sample_valid` held with data/chan stable.
  - `drop_count`=5.
  - After ready=1, next accepted sample is the channel following the held one, with no skipped value.
- LFSR. Setup: DWIDTH=32, mode=11, start_val=0. Expect:
  - First update yields 1.
  - Subsequent values match a reference Galois model with POLY for 100 samples.
  - Never 0.
- Period/enable edge cases. Setup: period=0, enable=1. Expect a sample every clock with ready=1. Then enable=0: no new samples and counter frozen; a pending sample is still accepted.
- Reset mid-operation. Assert reset for 1 clock while `sample_valid`=1 and `drop_count`=3. Expect next cycle:
  - valid=0, drop_count=0.
  - First post-reset sample is (0,RESET_VAL).
